// File: rtl/fifo_byte_packer.sv
// rtl/fifo_byte_packer.sv - pops bytes from an upstream FIFO and packs them into wide words
// A flush pushes out a partially filled word; output uses a valid/ready handshake.
module fifo_byte_packer #(
    parameter int width = 8,
    parameter int bytes = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         empty,
    input  logic [width-1:0]             fifoData,
    output logic                         read,
    input  logic                         flush,
    output logic [width*bytes-1:0]       outData,
    output logic [$clog2(bytes+1)-1:0]   outCount,
    output logic                         outValid,
    input  logic                         outReady
);
    localparam int CW = $clog2(bytes + 1);
    localparam int SW = CW + 1;
    localparam int LW = $clog2(bytes);

    typedef enum logic {FILL, HOLD} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic            pending;
    logic            flushReq;
    logic [SW-1:0]   fill_sum;
    logic [LW-1:0]   lane;

    // One extra bit so cnt plus an in-flight pop can never wrap.
    assign fill_sum = SW'(cnt) + SW'(pending);
    assign cnt_inc  = cnt + CW'(1);
    assign lane     = cnt[LW-1:0];

    assign read = (state == FILL) & ~empty & ~flushReq & ~flush
                & (fill_sum < SW'(bytes)) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            cnt      <= '0;
            pending  <= 1'b0;
            flushReq <= 1'b0;
            outData  <= '0;
            outCount <= '0;
            outValid <= 1'b0;
        end else if (state == FILL) begin
            pending <= read;
            if (pending) begin
                outData[int'(lane)*width +: width] <= fifoData;
                cnt <= cnt_inc;
                if (cnt_inc == CW'(bytes)) begin
                    // A completing capture wins over a simultaneous flush.
                    state    <= HOLD;
                    outValid <= 1'b1;
                    outCount <= CW'(bytes);
                    flushReq <= 1'b0;
                end else if (flush) begin
                    flushReq <= 1'b1;
                end
            end else if (flushReq) begin
                if (cnt != '0) begin
                    state    <= HOLD;
                    outValid <= 1'b1;
                    outCount <= cnt;
                end else begin
                    flushReq <= 1'b0;
                end
            end else if (flush) begin
                flushReq <= 1'b1;
            end
        end else begin
            if (outReady) begin
                state    <= FILL;
                cnt      <= '0;
                flushReq <= 1'b0;
                outValid <= 1'b0;
                outData  <= '0;
                outCount <= '0;
            end
        end
    end
endmodule
